instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage between the program counter and decode.
//  - Issues the current PC (i_address) to instruction memory over a req/ack handshake.
//  - Latches the returned word into the instruction register (IR) and presents it to decode with valid/ready.
//  - Drives the PC's IF step pulse; handles flush/redirect and memory timeout.
// PARAMETERS
//  TIMEOUT   256         max wait cycles for imem_ack; 0 disables the timeout
//  NOP_INSN  32'h5400_0000  word placed in IR on timeout
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  reset       in   1   synchronous, active-high reset
//  i_address   in   32  current PC value
//  if_step     out  1   one-cycle pulse; PC advances/redirects on the next edge
//  flush       in   1   redirect from control; pc_cmd/pc_v valid this cycle
//  imem_req    out  1   fetch request; imem_addr valid while high
//  imem_addr   out  32  fetch address (= i_address while requesting)
//  imem_ack    in   1   one-cycle response strobe, imem_rdata valid with it
//  imem_rdata  in   32  fetched instruction word
//  ir_valid    out  1   IR holds an instruction for decode
//  ir_ready    in   1   decode accepts IR this cycle
//  ir_data     out  32  instruction register
//  ir_pc       out  32  address the IR word was fetched from
//  ir_err      out  1   IR content is NOP_INSN due to timeout
//  fetch_cnt   out  32  count of instructions delivered (wraps)
// BEHAVIOUR
//  Reset: state=IDLE; ir_valid=0, ir_data=0, ir_pc=0, ir_err=0, fetch_cnt=0, wait counter=0.
//    - imem_req and if_step are 0 while reset is high.
//    - Reset mid-transaction abandons it; a late ack is ignored in IDLE.
//  States: IDLE, FETCH, FULL, DROP.
//    - imem_req = state in {FETCH, DROP}.
//    - imem_addr = i_address; the PC is stable because if_step is 0 until ack.
//  IDLE:  -> FETCH on the next cycle. flush here pulses if_step.
//  FETCH: wait counter increments each cycle without ack.
//    - ack & !flush: if_step=1; IR<=rdata; ir_pc<=imem_addr; ir_err<=0; -> FULL.
//    - flush (with or without ack): if_step=1 (single pulse); data discarded.
//      -> FETCH if ack this cycle, else -> DROP.
//    - counter reaches TIMEOUT with no ack: IR<=NOP_INSN; ir_pc<=imem_addr; ir_err<=1; if_step=0; -> FULL.
//      Control resolves the fault. The late ack of the abandoned request is ignored.
//  FULL:  ir_valid=1; IR/ir_pc/ir_err stay stable until consumed.
//    - ir_ready & !flush: fetch_cnt+1; -> FETCH.
//    - flush: ir_valid drops next cycle, no count, if_step=1; -> FETCH. flush wins over ir_ready.
//  DROP: request outstanding but stale; hold req/addr.
//    - ack: discard; -> FETCH (new address).
//    - flush: if_step=1; stay DROP.
//    - timeout: -> FETCH silently, ir_err unaffected.
//  Wait counter clears on every state entry; width $clog2(TIMEOUT+1).
//  Latency: ack at cycle N -> ir_valid at N+1; ready at M -> imem_req at M+1.
//    Minimum 3 cycles/instruction with 1-cycle memory.
//  ir_valid=0 outside FULL; ir_data holds its last value.
// TESTING
//  1. Reset, memory acks 1 cycle after req, ir_ready=1:
//     addr 0,4,8 fetched; ir_data matches; fetch_cnt=3 after 3 deliveries.
//  2. ir_ready=0 for 10 cycles in FULL -> ir_valid/ir_data stable, imem_req=0, no if_step; then ready -> req next cycle.
//  3. Flush 2 cycles into 5-cycle ack wait -> one if_step pulse; ack data 32'hDEAD_BEEF never appears in IR;
//     next req uses redirected address 32'h100.
//  4. flush and imem_ack in same FETCH cycle -> one if_step, IR unchanged, FETCH next cycle.
//  5. TIMEOUT=4, no ack -> after 4 wait cycles ir_valid=1, ir_err=1, ir_data=NOP_INSN, no if_step.
//  6. reset asserted in FETCH and FULL -> next cycle req=0, ir_valid=0, fetch_cnt=0; ack during reset ignored.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage that issues the PC to instruction memory over req/ack,
// holds the returned word in IR for decode and handles flush/redirect and memory timeout.
module instr_fetch #(
   parameter int          TIMEOUT  = 256,
   parameter logic [31:0] NOP_INSN = 32'h5400_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_address,
   output logic        if_step,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic [31:0] ir_data,
   output logic [31:0] ir_pc,
   output logic        ir_err,
   output logic [31:0] fetch_cnt
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;
   localparam logic [1:0] DROP  = 2'd3;
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] wait_q, wait_d;
   logic [31:0]   ir_data_q, ir_data_d, ir_pc_q, ir_pc_d, fetch_cnt_q, fetch_cnt_d;
   logic          ir_err_q, ir_err_d, step, tmo;

   // timeout fires on the cycle the wait counter would reach TIMEOUT
   assign tmo = (TIMEOUT != 0) && (wait_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      ir_data_d   = ir_data_q;
      ir_pc_d     = ir_pc_q;
      ir_err_d    = ir_err_q;
      fetch_cnt_d = fetch_cnt_q;
      step        = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            step    = flush;
         end
         FETCH: begin
            if (flush) begin
               step    = 1'b1;
               state_d = imem_ack ? FETCH : DROP;
            end else if (imem_ack || tmo) begin
               step      = imem_ack;
               ir_data_d = imem_ack ? imem_rdata : NOP_INSN;
               ir_pc_d   = i_address;
               ir_err_d  = !imem_ack;
               state_d   = FULL;
            end
         end
         FULL: begin
            step        = flush;
            fetch_cnt_d = fetch_cnt_q + ((ir_ready && !flush) ? 32'd1 : 32'd0);
            state_d     = (flush || ir_ready) ? FETCH : FULL;
         end
         default: begin
            step    = flush;
            state_d = (imem_ack || tmo) ? FETCH : DROP;
         end
      endcase
      wait_d = (state_d != state_q || (state_q == FETCH && flush) || state_q == IDLE || state_q == FULL)
               ? '0 : wait_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         ir_data_q   <= '0;
         ir_pc_q     <= '0;
         ir_err_q    <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         ir_data_q   <= ir_data_d;
         ir_pc_q     <= ir_pc_d;
         ir_err_q    <= ir_err_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign if_step   = !reset && step;
   assign imem_req  = !reset && (state_q == FETCH || state_q == DROP);
   assign imem_addr = i_address;
   assign ir_valid  = state_q == FULL;
   assign ir_data   = ir_data_q;
   assign ir_pc     = ir_pc_q;
   assign ir_err    = ir_err_q;
   assign fetch_cnt = fetch_cnt_q;
endmodule
